// File: rtl/cpa_trace_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : cpa_trace_sequencer
// Purpose  : Runs a CPA campaign: pulses the plaintext generator, frames the
//            AES run with the scope trigger and captures each ciphertext.
// Revision : 1.0  initial release
// ============================================================================
module cpa_trace_sequencer #(
    parameter int unsigned N_TRACES    = 1000,
    parameter int unsigned TRIG_PRE    = 4,
    parameter int unsigned GAP_CYCLES  = 16,
    parameter int unsigned AES_TIMEOUT = 64
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         abort_i,
    output logic         gen_ena_o,
    output logic         aes_start_o,
    input  logic         aes_done_i,
    input  logic [127:0] cipher_in_i,
    output logic [127:0] cipher_out_o,
    output logic         cipher_valid_o,
    output logic         trigger_o,
    output logic [31:0]  trace_count_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         timeout_err_o
);

    // Terminal values of the shared per-state cycle counter.
    localparam logic [31:0] C_N_TRACES  = N_TRACES;
    localparam logic [31:0] C_TRIG_LAST = (TRIG_PRE > 0) ? TRIG_PRE - 1 : 0;
    localparam logic [31:0] C_GAP_LAST  = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam logic [31:0] C_RUN_LAST  = (AES_TIMEOUT > 1) ? AES_TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_TRIG   = 3'd3,
        S_RUN    = 3'd4,
        S_GAP    = 3'd5,
        S_DONE   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    cnt_q, cnt_d;
    logic [31:0]    count_q, count_d;
    logic [127:0]   cipher_q, cipher_d;
    logic           gen_ena_q, gen_ena_d;
    logic           aes_start_q, aes_start_d;
    logic           trigger_q, trigger_d;
    logic           cipher_valid_q, cipher_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           err_q, err_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = '0;
        count_d  = count_q;
        cipher_d = cipher_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    count_d  = '0;
                    cipher_d = '0;
                    if (C_N_TRACES == 32'd0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (TRIG_PRE == 0) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (cnt_q == C_TRIG_LAST) begin
                    state_d = S_RUN;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_RUN: begin
                // cnt_q is zero on the aes_start cycle, where aes_done is not trusted.
                if (aes_done_i && (cnt_q != 32'd0)) begin
                    cipher_d = cipher_in_i;
                    count_d  = count_q + 32'd1;
                    state_d  = S_GAP;
                end else if (cnt_q >= C_RUN_LAST) begin
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == C_GAP_LAST) begin
                    if (count_q == C_N_TRACES) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything, including a completion in the same cycle.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            count_d  = count_q;
            cipher_d = cipher_q;
        end

        gen_ena_d      = (state_d == S_LOAD);
        aes_start_d    = (state_d == S_RUN) && (state_q != S_RUN);
        trigger_d      = (state_d == S_TRIG) || (state_d == S_RUN);
        cipher_valid_d = (state_q == S_RUN) && (state_d == S_GAP);
        busy_d         = (state_d == S_LOAD) || (state_d == S_SETTLE) ||
                         (state_d == S_TRIG) || (state_d == S_RUN)    ||
                         (state_d == S_GAP);
        done_d         = (state_d == S_DONE);
        err_d          = (state_d == S_ERR);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            count_q        <= '0;
            cipher_q       <= '0;
            gen_ena_q      <= 1'b0;
            aes_start_q    <= 1'b0;
            trigger_q      <= 1'b0;
            cipher_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            count_q        <= count_d;
            cipher_q       <= cipher_d;
            gen_ena_q      <= gen_ena_d;
            aes_start_q    <= aes_start_d;
            trigger_q      <= trigger_d;
            cipher_valid_q <= cipher_valid_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

    assign gen_ena_o      = gen_ena_q;
    assign aes_start_o    = aes_start_q;
    assign trigger_o      = trigger_q;
    assign cipher_out_o   = cipher_q;
    assign cipher_valid_o = cipher_valid_q;
    assign trace_count_o  = count_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign timeout_err_o  = err_q;

endmodule

`default_nettype wire

// File: doc/cpa_trace_sequencer.md
# cpa_trace_sequencer

Sequences CPA trace acquisition around the AES core. For each trace it:
- pulses the plaintext/key generator for a fresh LFSR plaintext,
- raises the oscilloscope trigger and starts the AES core,
- captures the ciphertext on completion.

It repeats this for a programmed number of traces. It sits between the CPA input generator, the AES core and the scope trigger pin, and is the only driver of the generator's enable.

## Interface
- N_TRACES, 1000: traces per campaign, 32-bit; 0 is legal.
- TRIG_PRE, 4: cycles trigger is high before aes_start; 0 is legal.
- GAP_CYCLES, 16: idle cycles between traces, trigger low; minimum 1 (values below 1 behave as 1).
- AES_TIMEOUT, 64: maximum cycles from aes_start to aes_done, 16-bit.
- clk  in  1  single clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; sampled on rising clk.
- start  in  1  begin campaign; sampled in IDLE, DONE, ERR.
- abort  in  1  stop campaign; sampled in any state other than IDLE.
- gen_ena  out  1  one-cycle pulse to the input generator's ena.
- aes_start  out  1  one-cycle pulse to the AES core.
- aes_done  in  1  AES core completion strobe.
- cipher_in  in  128  AES core ciphertext, valid when aes_done=1.
- cipher_out  out  128  last captured ciphertext.
- cipher_valid  out  1  one-cycle pulse; cipher_out was updated on the previous edge.
- trigger  out  1  scope trigger, registered.
- trace_count  out  32  completed traces in the current campaign.
- busy  out  1  high in LOAD, SETTLE, TRIG, RUN, GAP.
- done  out  1  high in DONE.
- timeout_err  out  1  high in ERR.

## Operation
- Reset: all outputs 0, state IDLE, internal counters 0.
- States: IDLE, LOAD, SETTLE, TRIG, RUN, GAP, DONE, ERR.
- IDLE/DONE/ERR with start=1:
  - trace_count and cipher_out are cleared.
  - Next state is LOAD, or DONE directly if N_TRACES=0.
- LOAD, 1 cycle: gen_ena=1. The generator registers a new plaintext on this edge.
- SETTLE, 1 cycle: waits while the plaintext register output propagates to the AES core.
- TRIG: trigger=1 for TRIG_PRE cycles, then RUN. With TRIG_PRE=0, SETTLE goes straight to RUN.
- RUN:
  - trigger=1 throughout; aes_start=1 on the first cycle only.
  - A timeout counter starts at 0 on the aes_start cycle and increments every RUN cycle.
  - aes_done is ignored on the aes_start cycle and honoured from the following cycle.
  - aes_done=1: cipher_out<=cipher_in, trace_count<=trace_count+1, go to GAP. cipher_valid=1 in the first GAP cycle.
  - If the counter reaches AES_TIMEOUT without aes_done: go to ERR. trace_count and cipher_out are not updated.
  - If aes_done and the timeout occur in the same cycle, aes_done wins.
- GAP: trigger=0 for GAP_CYCLES cycles. Then go to DONE if trace_count==N_TRACES, else LOAD.
- DONE and ERR hold until start or reset. trace_count and cipher_out are held.
- abort=1 in any non-IDLE state:
  - Next state is IDLE.
  - trigger, gen_ena and aes_start are 0 from the next cycle.
  - trace_count and cipher_out are held, so a partial count is readable.
  - abort has priority over every other transition, including aes_done in the same cycle.
- start outside IDLE/DONE/ERR is ignored.
- reset mid-campaign: next cycle is IDLE with all outputs 0. The generator is not pulsed again.
- trace_count does not wrap within a campaign, since N_TRACES is at most 2^32-1.

## Timing
- All outputs are registered, changing only on rising clk.
- start sampled at edge 0:
  - gen_ena high in cycle 1 (LOAD), SETTLE in cycle 2.
  - trigger high from cycle 3 to cycle 3+TRIG_PRE.
  - aes_start in cycle 3+TRIG_PRE.
- aes_done sampled in cycle k: cipher_valid and trigger=0 in cycle k+1.
- Per-trace period is 3 + TRIG_PRE + L + GAP_CYCLES cycles, where L is aes_start-to-aes_done latency (L≥1).
- Trigger rises exactly TRIG_PRE cycles before aes_start and falls exactly one cycle after aes_done, giving a fixed trace alignment.
- Exactly one gen_ena pulse per trace, so plaintext n is LFSR state n after generator reset.

## Test plan
- Nominal run, N_TRACES=3, TRIG_PRE=4, GAP_CYCLES=16, AES model with L=10, one start pulse:
  - 3 gen_ena pulses, 3 aes_start pulses, 3 cipher_valid pulses with matching ciphertexts.
  - Trigger high 15 cycles per trace.
  - done=1 with trace_count=3.
  - Period 33 cycles.
- TRIG_PRE=0, L=1: aes_start in cycle 3 after start; trigger high exactly 2 cycles per trace.
- AES model never asserts aes_done, AES_TIMEOUT=64:
  - ERR entered at cycle 64 after aes_start; timeout_err=1, trigger=0, trace_count=0.
  - A subsequent start restarts cleanly.
- abort in RUN of trace 2, in the same cycle as aes_done: IDLE next cycle, trace_count=1, no cipher_valid.
- N_TRACES=0: start leads to DONE on the next cycle, with no gen_ena, aes_start or trigger activity.
- Reset asserted during TRIG, then start:
  - All outputs are 0 the cycle after reset.
  - The new campaign begins with gen_ena one cycle after start.
  - start while busy is ignored.
